// File: rtl/conv_pool_phase_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : conv_pool_phase_scheduler_pkg
// Description : Shared types for the feature-map BRAM phase scheduler:
//               arbiter mode select and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pool_phase_scheduler_pkg;

  // Feature-map BRAM arbiter mode select
  typedef enum logic {
    MUX_CONVOLUTION = 1'b0,
    MUX_POOLING     = 1'b1
  } arbiter_mode_t;

  // Phase scheduler states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    DRAIN    = 3'd2,
    SWITCH_P = 3'd3,
    POOL     = 3'd4,
    SWITCH_C = 3'd5
  } sched_state_t;

  // States in which the scheduler waits on an engine and the timeout runs
  function automatic logic is_wait_state(input sched_state_t s);
    return (s == DRAIN) || (s == POOL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_pool_phase_scheduler_quiesce_timer.sv
`default_nettype none
// ============================================================================
// Module      : conv_pool_phase_scheduler_quiesce_timer
// Description : Guard counter. o_quiet is high in the cycle that completes
//               GUARD_CYCLES consecutive cycles with i_active low; any
//               activity restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pool_phase_scheduler_quiesce_timer #(
  parameter int GUARD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  output logic o_quiet
);

  localparam int            CW     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(GUARD_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count completed idle cycles, saturating one short of the guard length
  always_ff @(posedge clk) begin
    if (rst || i_active) begin
      r_cnt <= '0;
    end else if (r_cnt != C_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Current idle cycle is the last one needed to satisfy the guard
  assign o_quiet = !i_active && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/conv_pool_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_pool_phase_scheduler
// Description : Time-multiplexes the feature-map BRAM between convolution
//               and pooling engines. Mode changes only after both engines'
//               BRAM ports have been idle for GUARD_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pool_phase_scheduler
  import conv_pool_phase_scheduler_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TS_CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic                    timestep_i,
  input  logic                    conv_busy_i,
  input  logic                    conv_fifo_empty_i,
  input  logic                    conv_mem_act_i,
  input  logic                    pool_mem_act_i,
  input  logic                    pool_done_i,
  output logic                    conv_gate_o,
  output logic                    pool_start_o,
  output arbiter_mode_t           mode_o,
  output logic                    phase_done_o,
  output logic [TS_CNT_WIDTH-1:0] ts_count_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  localparam int             TOW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TOW-1:0] C_TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

  sched_state_t              r_state;
  sched_state_t              w_next;
  arbiter_mode_t             r_mode;
  logic                      r_pool_start;
  logic                      r_phase_done;
  logic [TS_CNT_WIDTH-1:0]   r_ts_count;
  logic                      r_pending;
  logic                      r_overrun;
  logic                      r_done_seen;
  logic [TOW-1:0]            r_to_cnt;
  logic                      r_timeout;
  logic                      w_guard_act;
  logic                      w_quiet;
  logic                      w_enter_sw_p;
  logic                      w_enter_sw_c;
  logic                      w_unused_fifo_empty;

  // FIFO occupancy is status only: leftover events wait for the next timestep
  assign w_unused_fifo_empty = conv_fifo_empty_i;

  conv_pool_phase_scheduler_quiesce_timer #(
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_quiesce_timer (
    .clk      (clk),
    .rst      (rst),
    .i_active (w_guard_act),
    .o_quiet  (w_quiet)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (enable_i) w_next = CONV;
      CONV:     if (timestep_i || r_pending) w_next = DRAIN;
      DRAIN:    if (w_quiet) w_next = SWITCH_P;
      SWITCH_P: w_next = POOL;
      POOL:     if (w_quiet) w_next = SWITCH_C;
      SWITCH_C: w_next = enable_i ? CONV : IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Combinational outputs and guard-timer activity mux
  always_comb begin
    conv_gate_o = (r_state == CONV);
    busy_o      = (r_state != IDLE);
    case (r_state)
      DRAIN:   w_guard_act = conv_busy_i | conv_mem_act_i;
      // Before pool_done the sweep is assumed to be using the BRAM
      POOL:    w_guard_act = !r_done_seen | pool_mem_act_i;
      default: w_guard_act = 1'b1;
    endcase
  end

  assign w_enter_sw_p = (r_state == DRAIN) && (w_next == SWITCH_P);
  assign w_enter_sw_c = (r_state == POOL)  && (w_next == SWITCH_C);

  // Registered mode select and phase pulses; mode flips as the guard completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= MUX_CONVOLUTION;
      r_pool_start <= 1'b0;
      r_phase_done <= 1'b0;
      r_ts_count   <= '0;
    end else begin
      r_pool_start <= (r_state == SWITCH_P);
      r_phase_done <= w_enter_sw_c;
      if (w_enter_sw_p) r_mode <= MUX_POOLING;
      else if (w_enter_sw_c) r_mode <= MUX_CONVOLUTION;
      if (w_enter_sw_c) r_ts_count <= r_ts_count + 1'b1;
    end
  end

  // Depth-1 timestep queue with sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (timestep_i && r_pending) begin
      r_overrun <= 1'b1;
    end else if (timestep_i && (r_state != CONV)) begin
      r_pending <= 1'b1;
    end else if (r_state == CONV) begin
      r_pending <= 1'b0;
    end
  end

  // Remember pool_done for the remainder of the POOL visit
  always_ff @(posedge clk) begin
    if (rst || (r_state != POOL)) r_done_seen <= 1'b0;
    else if (pool_done_i)         r_done_seen <= 1'b1;
  end

  // Wait-state timeout: counts cycles in DRAIN/POOL, restarts on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (is_wait_state(r_state) && (w_next == r_state)) begin
      if (r_to_cnt != C_TO_LAST) r_to_cnt <= r_to_cnt + 1'b1;
      else                       r_timeout <= 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign mode_o       = r_mode;
  assign pool_start_o = r_pool_start;
  assign phase_done_o = r_phase_done;
  assign ts_count_o   = r_ts_count;
  assign overrun_o    = r_overrun;
  assign timeout_o    = r_timeout;

endmodule
`default_nettype wire
